// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared constants and state encoding for the PISO serializer
package piso_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SYM_W_DEF  = 2;
  localparam int N_DEF      = DATA_W_DEF / SYM_W_DEF;

  // A single-symbol word still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(N_DEF);

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t SHIFT = 1'b1;

endpackage

// File: rtl/piso_sym_cnt.sv
// rtl/piso_sym_cnt.sv - down-counter of symbols remaining in the current word
module piso_sym_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso.sv
// rtl/piso.sv - parallel-in serial-out symbol serializer with stall and back-to-back accept
module piso
  import piso_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SYM_W     = SYM_W_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] par_in,
  input  logic              hold,
  output logic              ready,
  output logic [SYM_W-1:0]  ser_out,
  output logic              ser_valid,
  output logic              last
);

  localparam int N     = DATA_W / SYM_W;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [SYM_W-1:0]  head;
  logic              zero;
  logic              accept;
  logic              advance;

  // The outgoing symbol always sits at the end the shift moves away from.
  assign head = MSB_FIRST ? shreg[DATA_W-1 -: SYM_W] : shreg[SYM_W-1:0];

  assign last      = (state == SHIFT) && zero;
  assign ready     = (state == IDLE) || (last && !hold);
  assign accept    = load && ready;
  assign advance   = (state == SHIFT) && !hold;
  assign ser_valid = (state == SHIFT);
  assign ser_out   = (state == SHIFT) ? head : '0;

  piso_sym_cnt #(
    .W(CNT_W)
  ) u_sym_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (LAST_IDX),
    .dec      (advance && !zero),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
    end else if (accept) begin
      state <= SHIFT;
      shreg <= par_in;
    end else if (advance) begin
      if (zero) begin
        state <= IDLE;
        shreg <= '0;
      end else begin
        shreg <= MSB_FIRST ? (shreg << SYM_W) : (shreg >> SYM_W);
      end
    end
  end

endmodule

// File: doc/piso.md
PISO -- requirements
Module: piso

Interface
REQ-001 Parameter DATA_W, 8, parallel word width in bits.
REQ-002 Parameter SYM_W, 2, serial symbol width in bits; DATA_W SHALL be an integer multiple of SYM_W.
REQ-003 Parameter MSB_FIRST, 1, 1 = most-significant symbol sent first, 0 = least-significant first.
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load  input  1  request to accept par_in this cycle.
REQ-007 par_in  input  DATA_W  parallel word to serialize.
REQ-008 hold  input  1  stall; freezes shifting while high.
REQ-009 ready  output  1  block can accept a load this cycle.
REQ-010 ser_out  output  SYM_W  current serial symbol.
REQ-011 ser_valid  output  1  ser_out carries a valid symbol.
REQ-012 last  output  1  ser_out is the final symbol of the word.

Function
REQ-013 Block SHALL have two states, IDLE and SHIFT; N = DATA_W/SYM_W symbols per word (4 at defaults).
REQ-014 Accept SHALL occur on a rising edge where load & ready; par_in is captured into the shift register and the symbol counter is set to N-1.
REQ-015 ready SHALL be combinational: high in IDLE; high in SHIFT only when last is high and hold is low; low otherwise.
REQ-016 load while ready is low SHALL be ignored with no state change; par_in SHALL not be sampled.
REQ-017 First symbol SHALL appear on ser_out with ser_valid high in the cycle following the accept edge (latency 1); the N symbols occupy N consecutive cycles absent hold.
REQ-018 MSB_FIRST=1: symbol k (k=0..N-1) SHALL be par_in[DATA_W-1-k*SYM_W -: SYM_W]; MSB_FIRST=0: par_in[k*SYM_W +: SYM_W].
REQ-019 Each rising edge in SHIFT with hold low SHALL advance one symbol and decrement the counter; with hold high, ser_out, ser_valid, last and the counter SHALL remain unchanged.
REQ-020 last SHALL be high exactly while the counter is 0 in SHIFT.
REQ-021 Advancing past the last symbol with no accept SHALL return to IDLE: ser_valid=0, last=0, ser_out=0.
REQ-022 Accept on the last-symbol edge SHALL stay in SHIFT and present the new word's first symbol next cycle (zero-bubble back-to-back).
REQ-023 In IDLE, ser_out SHALL be 0 and ser_valid 0; hold in IDLE SHALL have no effect.

Reset
REQ-024 reset high at a rising edge SHALL force IDLE, counter=0, shift register=0, ser_out=0, ser_valid=0, last=0, overriding load and hold.
REQ-025 Reset mid-word SHALL discard remaining symbols; no partial word resumes after deassertion.
REQ-026 ready SHALL be high in the first cycle after reset deasserts.

Structure
REQ-027 Package piso_pkg SHALL hold DATA_W/SYM_W default constants, derived N and counter width, and the state typedef (IDLE, SHIFT).
REQ-028 Symbol counter SHALL be one sub-module, piso_sym_cnt (load, decrement-enable, zero flag); shift register and FSM stay in piso.

Verification
REQ-029 Reset then load=1, par_in=8'hB4, MSB_FIRST=1 -> ser_out 2'b10,2'b11,2'b01,2'b00 on cycles 1-4 after accept, last only on 4th, ready low cycles 1-3.
REQ-030 8'hB4 then 8'h1E loaded on the last-symbol cycle -> 8 contiguous valid symbols 10,11,01,00,00,01,11,10, no ser_valid gap.
REQ-031 8'hB4 with hold high for 3 cycles after 2nd symbol -> 2'b11 held 4 cycles, then 01,00; last timing shifts by 3.
REQ-032 load=1, par_in=8'hFF asserted every cycle during an 8'hB4 word -> 8'hFF accepted only on the last-symbol cycle; B4 symbols uncorrupted.
REQ-033 reset pulse during 2nd symbol of 8'hB4 -> next cycle ser_valid=0, ser_out=0, ready=1; no further B4 symbols.
REQ-034 MSB_FIRST=0, par_in=8'hB4 -> ser_out 00,01,11,10; round-trip through the team's SIPO receiver with matching order reproduces 8'hB4.
